// File: rtl/tutorial_aula_irq_ctrl.sv
// Avalon-MM interrupt controller: per-line level/edge latching, masking and a
// priority-encoded active-line register feeding one registered CPU interrupt.
module tutorial_aula_irq_ctrl #(
  parameter int NUM_IRQ = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq
);

  localparam logic [2:0] ADDR_PENDING = 3'd0;
  localparam logic [2:0] ADDR_ENABLE  = 3'd1;
  localparam logic [2:0] ADDR_MODE    = 3'd2;
  localparam logic [2:0] ADDR_ACTIVE  = 3'd3;
  localparam logic [2:0] ADDR_RAW     = 3'd4;
  localparam logic [2:0] ADDR_FORCE   = 3'd5;

  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] enable_q, enable_d;
  logic [NUM_IRQ-1:0] mode_q, mode_d;
  logic [NUM_IRQ-1:0] irq_hist_q, irq_hist_d;
  logic               irq_q, irq_d;
  logic [15:0]        readdata_q, readdata_d;

  logic               wr_en;
  logic [NUM_IRQ-1:0] wdata;
  logic [NUM_IRQ-1:0] set_vec, clr_vec, active_vec;
  logic               active_vld;
  logic [3:0]         active_idx;

  function automatic logic [15:0] zext(input logic [NUM_IRQ-1:0] v);
    logic [15:0] r;
    r = '0;
    r[NUM_IRQ-1:0] = v;
    return r;
  endfunction

  always_comb begin
    wr_en = chipselect && !write_n;
    wdata = writedata[NUM_IRQ-1:0];

    // Set beats clear, so a level line held high cannot be acknowledged away.
    set_vec = (mode_q & irq_in & ~irq_hist_q) | (~mode_q & irq_in);
    if (wr_en && address == ADDR_FORCE) set_vec = set_vec | wdata;
    clr_vec = (wr_en && address == ADDR_PENDING) ? wdata : '0;
    pending_d = set_vec | (pending_q & ~clr_vec);

    enable_d   = (wr_en && address == ADDR_ENABLE) ? wdata : enable_q;
    mode_d     = (wr_en && address == ADDR_MODE)   ? wdata : mode_q;
    irq_hist_d = irq_in;

    active_vec = pending_q & enable_q;
    irq_d      = |active_vec;

    // Scan downward so the lowest index wins.
    active_vld = 1'b0;
    active_idx = 4'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active_vec[i]) begin
        active_vld = 1'b1;
        active_idx = 4'(i);
      end
    end

    readdata_d = 16'h0000;
    case (address)
      ADDR_PENDING: readdata_d = zext(pending_q);
      ADDR_ENABLE:  readdata_d = zext(enable_q);
      ADDR_MODE:    readdata_d = zext(mode_q);
      ADDR_ACTIVE:  readdata_d = {active_vld, 11'd0, active_idx};
      ADDR_RAW:     readdata_d = zext(irq_in);
      default:      readdata_d = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q  <= '0;
      enable_q   <= '0;
      mode_q     <= '0;
      irq_hist_q <= '0;
      irq_q      <= 1'b0;
      readdata_q <= 16'h0000;
    end else begin
      pending_q  <= pending_d;
      enable_q   <= enable_d;
      mode_q     <= mode_d;
      irq_hist_q <= irq_hist_d;
      irq_q      <= irq_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_tutorial_aula_irq_ctrl.sv
// Directed bench for tutorial_aula_irq_ctrl; register reads are scored
// against expected values queued when each read is issued.
module tb_tutorial_aula_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic [15:0] irq_in;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  tutorial_aula_irq_ctrl #(.NUM_IRQ(16)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .irq_in(irq_in), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = 16'h0000;
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [15:0] exp);
    exp_q.push_back(exp);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    tick();
    chipselect = 1'b0;
    chk(tag, readdata, exp_q.pop_front());
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    chk(tag, {15'd0, irq}, {15'd0, exp});
  endtask

  initial begin
    reset_n = 1'b0; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = 16'h0000; irq_in = 16'h0000;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Reset state: all addresses read zero, irq low.
    for (int a = 0; a < 8; a++) rd($sformatf("reset_rd%0d", a), 3'(a), 16'h0000);
    chk_irq("reset_irq", 1'b0);

    // Level mode on line 0.
    wr(3'd1, 16'h0001);
    irq_in = 16'h0001;
    tick();
    chk_irq("lvl_irq_lag", 1'b0);
    rd("lvl_pending", 3'd0, 16'h0001);
    chk_irq("lvl_irq_set", 1'b1);
    wr(3'd0, 16'h0001);
    rd("lvl_w1c_held", 3'd0, 16'h0001);
    irq_in = 16'h0000;
    wr(3'd0, 16'h0001);
    chk_irq("lvl_irq_after_w1c", 1'b1);
    tick();
    chk_irq("lvl_irq_clear", 1'b0);
    rd("lvl_pending_clear", 3'd0, 16'h0000);

    // Edge mode on line 2 with a one-cycle pulse.
    wr(3'd2, 16'h0004);
    wr(3'd1, 16'h0004);
    irq_in = 16'h0004;
    tick();
    irq_in = 16'h0000;
    tick();
    rd("edge_pending", 3'd0, 16'h0004);
    rd("edge_active", 3'd3, 16'h8002);
    rd("mode_rd", 3'd2, 16'h0004);
    wr(3'd0, 16'h0004);
    rd("edge_w1c", 3'd0, 16'h0000);
    rd("edge_active_clr", 3'd3, 16'h0000);

    // Rising edge on line 3 coincident with its W1C: set wins.
    wr(3'd2, 16'h000C);
    irq_in = 16'h0008;
    wr(3'd0, 16'h0008);
    rd("set_beats_clr", 3'd0, 16'h0008);
    irq_in = 16'h0000;
    wr(3'd0, 16'h0008);
    rd("edge3_clear", 3'd0, 16'h0000);

    // Priority encoding through FORCE and ENABLE.
    wr(3'd5, 16'h0220);
    wr(3'd1, 16'h0200);
    rd("active_9", 3'd3, 16'h8009);
    wr(3'd1, 16'h0220);
    rd("active_5", 3'd3, 16'h8005);
    wr(3'd5, 16'h0001);
    wr(3'd1, 16'h0221);
    rd("active_0", 3'd3, 16'h8000);
    rd("force_reads0", 3'd5, 16'h0000);
    wr(3'd3, 16'hFFFF);
    rd("active_ro", 3'd3, 16'h8000);
    rd("pending_forced", 3'd0, 16'h0221);
    rd("rsvd6", 3'd6, 16'h0000);
    chk_irq("prio_irq", 1'b1);

    // Raw view, then asynchronous reset mid-cycle.
    wr(3'd2, 16'h0080);
    irq_in = 16'h0080;
    rd("raw", 3'd4, 16'h0080);
    tick();
    chk_irq("pre_reset_irq", 1'b1);
    chk("pre_reset_rd", readdata, 16'h0080);
    #2;
    reset_n = 1'b0;
    #1;
    chk_irq("async_rst_irq", 1'b0);
    chk("async_rst_rd", readdata, 16'h0000);
    #1;
    reset_n = 1'b1;
    rd("post_rst_pending0", 3'd0, 16'h0000);
    rd("post_rst_pending", 3'd0, 16'h0080);
    rd("post_rst_enable", 3'd1, 16'h0000);
    rd("post_rst_mode", 3'd2, 16'h0000);
    chk_irq("post_rst_irq", 1'b0);
    irq_in = 16'h0000;
    wr(3'd0, 16'h0080);
    rd("final_clear", 3'd0, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
